// File: rtl/dbi_pkg.sv
// Shared DBI constants, used by both the DBI encoder and decoder.
//   BW         : decoded data width (encoded bus carries BW+1 bits)
//   CW         : statistics counter width
//   HALF       : transition bound; more than HALF toggled lines is a violation
//   FIFO_DEPTH : decoder output buffer depth
package dbi_pkg;

  localparam int unsigned BW         = 128;
  localparam int unsigned CW         = 16;
  localparam int unsigned HALF       = BW / 2;
  localparam int unsigned FIFO_DEPTH = 2;

  // FIFO occupancy, 0..FIFO_DEPTH
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/popcount_bw.sv
// Combinational population count built as a balanced adder tree.
//   vec_i : W-bit input vector
//   cnt_o : number of ones in vec_i, $clog2(W+1) bits
module popcount_bw #(
  parameter int unsigned W = dbi_pkg::BW
) (
  input  logic [W-1:0]             vec_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int unsigned OW = $clog2(W + 1);
  localparam int unsigned LV = (W <= 1) ? 0 : $clog2(W);
  localparam int unsigned N  = 1 << LV;

  // Level 0 holds the leaves (zero-padded to a power of two); each further
  // level sums adjacent pairs of the level below, so the root is level LV.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int unsigned NL = N >> l;
    logic [OW-1:0] s [NL];
    for (genvar i = 0; i < NL; i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < W) begin : g_in
          assign s[i] = OW'(vec_i[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_sum
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign cnt_o = g_lvl[LV].s[0];

endmodule

// File: rtl/dbi_decode_128b.sv
// DBI decoder with a 2-entry output FIFO and transition statistics.
//   clk, reset     : clock; synchronous active-low reset
//   dbi_en         : 1 = honour DBI flag (data_in[BW]); 0 = pass-through
//   data_in        : {flag, bus[BW-1:0]}
//   in_valid/ready : upstream handshake
//   data_out/out_valid/out_ready : downstream handshake, head of FIFO
//   clr_stats      : synchronous clear of the statistics (wins over events)
//   inv_cnt        : saturating count of words decoded as inverted
//   viol_cnt       : saturating count of words toggling more than BW/2 lines
//   viol_sticky    : set on any violation since the last clear
module dbi_decode_128b
  import dbi_pkg::*;
#(
  parameter int unsigned BW = dbi_pkg::BW,
  parameter int unsigned CW = dbi_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbi_en,
  input  logic [BW:0]   data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          clr_stats,
  output logic [CW-1:0] inv_cnt,
  output logic [CW-1:0] viol_cnt,
  output logic          viol_sticky
);

  localparam int unsigned PCW = $clog2(BW + 1);

  logic [BW-1:0] mem_q [FIFO_DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  occ_t          count_q, count_d;
  logic [BW-1:0] prev_q, prev_d;
  logic [CW-1:0] inv_cnt_q, inv_cnt_d;
  logic [CW-1:0] viol_cnt_q, viol_cnt_d;
  logic          sticky_q, sticky_d;

  logic          accept, pop, inv_evt, viol_evt;
  logic [BW-1:0] bus, word;
  logic [PCW-1:0] toggles;

  assign bus = data_in[BW-1:0];

  popcount_bw #(.W(BW)) u_popcount (
    .vec_i (prev_q ^ bus),
    .cnt_o (toggles)
  );

  assign in_ready    = (count_q != occ_t'(FIFO_DEPTH));
  assign out_valid   = (count_q != '0);
  assign data_out    = mem_q[rd_ptr_q];
  assign inv_cnt     = inv_cnt_q;
  assign viol_cnt    = viol_cnt_q;
  assign viol_sticky = sticky_q;

  always_comb begin
    // reset gating keeps the FIFO storage untouched during reset
    accept   = in_valid & in_ready & reset;
    pop      = out_valid & out_ready;
    word     = (dbi_en & data_in[BW]) ? ~bus : bus;
    inv_evt  = accept & dbi_en & data_in[BW];
    viol_evt = accept & dbi_en & (toggles > PCW'(BW / 2));

    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    prev_d   = accept ? bus : prev_q;

    count_d = count_q;
    if (accept && !pop)      count_d = count_q + 2'd1;
    else if (!accept && pop) count_d = count_q - 2'd1;

    inv_cnt_d  = inv_cnt_q;
    viol_cnt_d = viol_cnt_q;
    sticky_d   = sticky_q;
    if (clr_stats) begin
      inv_cnt_d  = '0;
      viol_cnt_d = '0;
      sticky_d   = 1'b0;
    end else begin
      if (inv_evt && inv_cnt_q != '1)   inv_cnt_d  = inv_cnt_q + CW'(1);
      if (viol_evt && viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + CW'(1);
      if (viol_evt)                     sticky_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      prev_q     <= '0;
      inv_cnt_q  <= '0;
      viol_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      inv_cnt_q  <= inv_cnt_d;
      viol_cnt_q <= viol_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_dbi_decode_128b.sv
// Self-checking bench for dbi_decode_128b against a queue-based reference model.
module tb_dbi_decode_128b;

  localparam int BW   = 128;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, dbi_en, in_valid, out_ready, clr_stats;
  logic [BW:0]   data_in;
  logic          in_ready, out_valid, viol_sticky;
  logic [BW-1:0] data_out;
  logic [CW-1:0] inv_cnt, viol_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_prev;
  int            m_inv, m_viol;
  bit            m_sticky;

  dbi_decode_128b #(.BW(BW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .dbi_en      (dbi_en),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clr_stats   (clr_stats),
    .inv_cnt     (inv_cnt),
    .viol_cnt    (viol_cnt),
    .viol_sticky (viol_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle, advance the model, wait to 1 time unit past the edge.
  task automatic cycle(input bit rst_n, input bit en, input logic [BW:0] din,
                       input bit iv, input bit ordy, input bit clr);
    bit acc, pp, ev_inv, ev_viol;
    logic [BW-1:0] bus;
    reset = rst_n; dbi_en = en; data_in = din;
    in_valid = iv; out_ready = ordy; clr_stats = clr;
    if (!rst_n) begin
      mq.delete(); m_prev = '0; m_inv = 0; m_viol = 0; m_sticky = 0;
    end else begin
      acc = iv && (mq.size() < 2);
      pp  = (mq.size() > 0) && ordy;
      bus = din[BW-1:0];
      ev_inv = 0; ev_viol = 0;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back((en && din[BW]) ? ~bus : bus);
        ev_inv  = en && din[BW];
        ev_viol = en && ($countones(m_prev ^ bus) > BW / 2);
        m_prev  = bus;
      end
      if (clr) begin
        m_inv = 0; m_viol = 0; m_sticky = 0;
      end else begin
        if (ev_inv && m_inv < CMAX) m_inv++;
        if (ev_viol) begin
          if (m_viol < CMAX) m_viol++;
          m_sticky = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, '0, 0, 0, 0);
    cycle(0, 0, '0, 1, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (inv_cnt !== 16'd0) begin errors++; $display("FAIL reset_inv_cnt got %0d want 0", inv_cnt); end
    checks++; if (viol_cnt !== 16'd0 || viol_sticky !== 1'b0) begin errors++; $display("FAIL reset_viol got %0d/%0b want 0/0", viol_cnt, viol_sticky); end
  endtask

  task automatic test_decode();
    logic [BW-1:0] ones;
    ones = '1;
    cycle(0, 0, '0, 0, 0, 0);
    cycle(1, 1, {1'b1, {BW{1'b0}}}, 1, 1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid got %0b want 1", out_valid); end
    checks++; if (data_out !== ones) begin errors++; $display("FAIL decode_data got %h want %h", data_out, ones); end
    checks++; if (inv_cnt !== 16'd1) begin errors++; $display("FAIL decode_inv_cnt got %0d want 1", inv_cnt); end
    cycle(1, 1, '0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] a, b, c;
    a = rand_word(); b = rand_word(); c = rand_word();
    cycle(0, 0, '0, 0, 0, 0);
    cycle(1, 0, {1'b0, a}, 1, 0, 0);
    checks++; if (in_ready !== 1'b1 || data_out !== a) begin errors++; $display("FAIL bp_after_a got rdy=%0b %h want rdy=1 %h", in_ready, data_out, a); end
    cycle(1, 0, {1'b0, b}, 1, 0, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
    cycle(1, 0, {1'b0, c}, 1, 0, 0);
    checks++; if (in_ready !== 1'b0 || data_out !== a || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%0b v=%0b %h want rdy=0 v=1 %h", in_ready, out_valid, data_out, a); end
    cycle(1, 0, {1'b0, c}, 1, 1, 0);
    checks++; if (data_out !== b || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got rdy=%0b %h want rdy=1 %h", in_ready, data_out, b); end
    cycle(1, 0, {1'b0, c}, 1, 1, 0);
    checks++; if (data_out !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got v=%0b %h want v=1 %h", out_valid, data_out, c); end
    cycle(1, 0, '0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b want 0", out_valid); end
  endtask

  task automatic test_violation();
    logic [BW-1:0] v80, d64, d65;
    v80 = {{48{1'b0}}, {80{1'b1}}};
    d64 = v80 ^ {{64{1'b0}}, {64{1'b1}}};
    d65 = d64 ^ {{63{1'b0}}, {65{1'b1}}};
    cycle(0, 0, '0, 0, 0, 0);
    cycle(1, 1, {1'b0, v80}, 1, 1, 0);
    checks++; if (viol_cnt !== 16'd1 || viol_sticky !== 1'b1) begin errors++; $display("FAIL viol_80 got %0d/%0b want 1/1", viol_cnt, viol_sticky); end
    cycle(1, 1, {1'b0, d64}, 1, 1, 0);
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL viol_64_bound got %0d want 1", viol_cnt); end
    cycle(1, 1, {1'b0, d65}, 1, 1, 0);
    checks++; if (viol_cnt !== 16'd2) begin errors++; $display("FAIL viol_65 got %0d want 2", viol_cnt); end
    checks++; if (inv_cnt !== 16'd0 || data_out !== d65) begin errors++; $display("FAIL viol_data got inv=%0d %h want inv=0 %h", inv_cnt, data_out, d65); end
    cycle(1, 0, '0, 0, 1, 0);
  endtask

  task automatic test_passthrough();
    logic [BW-1:0] a5, x, y;
    a5 = {16{8'hA5}}; x = rand_word(); y = rand_word();
    cycle(0, 0, '0, 0, 0, 0);
    cycle(1, 0, {1'b1, a5}, 1, 0, 0);
    checks++; if (data_out !== a5 || inv_cnt !== 16'd0) begin errors++; $display("FAIL pass_data got %h inv=%0d want %h inv=0", data_out, inv_cnt, a5); end
    cycle(1, 0, {1'b1, ~a5}, 1, 0, 0);
    checks++; if (viol_cnt !== 16'd0 || viol_sticky !== 1'b0) begin errors++; $display("FAIL pass_no_viol got %0d/%0b want 0/0", viol_cnt, viol_sticky); end
    cycle(1, 0, '0, 0, 1, 0);
    checks++; if (data_out !== ~a5) begin errors++; $display("FAIL pass_second got %h want %h", data_out, ~a5); end
    cycle(1, 0, '0, 0, 1, 0);
    cycle(1, 1, {1'b1, x}, 1, 0, 0);
    cycle(1, 0, {1'b1, y}, 0, 0, 0);
    checks++; if (data_out !== ~x) begin errors++; $display("FAIL en_change_stored got %h want %h", data_out, ~x); end
    cycle(1, 0, '0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [BW:0] din;
    cycle(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      din = {1'($urandom), rand_word()};
      cycle(1, 1'($urandom_range(0, 3) != 0), din, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, mq.size() != 0); end
      checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %0b want %0b", i, in_ready, mq.size() < 2); end
      if (mq.size() > 0) begin
        checks++; if (data_out !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, data_out, mq[0]); end
      end
      checks++; if (int'(inv_cnt) != m_inv) begin errors++; $display("FAIL rnd_inv[%0d] got %0d want %0d", i, inv_cnt, m_inv); end
      checks++; if (int'(viol_cnt) != m_viol || viol_sticky !== m_sticky) begin errors++; $display("FAIL rnd_viol[%0d] got %0d/%0b want %0d/%0b", i, viol_cnt, viol_sticky, m_viol, m_sticky); end
    end
  endtask

  task automatic test_saturation_clear();
    cycle(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 65539; i++) cycle(1, 1, {1'b1, {BW{1'b0}}}, 1, 1, 0);
    checks++; if (inv_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_inv got %h want ffff", inv_cnt); end
    checks++; if (out_valid !== 1'b1 || data_out !== mq[0]) begin errors++; $display("FAIL sat_stream got v=%0b %h", out_valid, data_out); end
    cycle(1, 1, {1'b1, {BW{1'b0}}}, 1, 1, 1);
    checks++; if (inv_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins got %0d want 0", inv_cnt); end
    cycle(1, 1, {1'b1, {BW{1'b0}}}, 1, 1, 0);
    checks++; if (inv_cnt !== 16'd1) begin errors++; $display("FAIL after_clr got %0d want 1", inv_cnt); end
    cycle(1, 0, '0, 0, 1, 0);
  endtask

  task automatic test_midstream_reset();
    logic [BW-1:0] w;
    w = rand_word();
    cycle(0, 0, '0, 0, 0, 0);
    cycle(1, 1, {1'b1, rand_word()}, 1, 0, 0);
    cycle(1, 1, {1'b1, ~m_prev}, 1, 0, 0);
    checks++; if (in_ready !== 1'b0 || inv_cnt !== 16'd2) begin errors++; $display("FAIL mid_full got rdy=%0b inv=%0d want rdy=0 inv=2", in_ready, inv_cnt); end
    cycle(0, 1, {1'b1, rand_word()}, 1, 0, 0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    checks++; if (inv_cnt !== 16'd0 || viol_cnt !== 16'd0 || viol_sticky !== 1'b0) begin errors++; $display("FAIL mid_reset_stats got %0d/%0d/%0b want 0/0/0", inv_cnt, viol_cnt, viol_sticky); end
    cycle(1, 0, {1'b0, w}, 1, 0, 0);
    checks++; if (out_valid !== 1'b1 || data_out !== w) begin errors++; $display("FAIL mid_latency got v=%0b %h want v=1 %h", out_valid, data_out, w); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_violation();
    test_passthrough();
    test_back_to_back();
    test_saturation_clear();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbi_decode_128b.md
DBI_DECODE_128B -- requirements
Module: dbi_decode_128b

Interface
REQ-001 SHALL have parameter BW, default 128: decoded data width; the encoded bus is BW+1 bits.
REQ-002 SHALL have parameter CW, default 16: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port dbi_en, input, 1 bit: 1 means decode the DBI flag; 0 means pass data through.
REQ-006 SHALL have port data_in, input, BW+1 bits: bit BW is the DBI flag, bits BW-1:0 are the bus lines.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-008 SHALL have port in_ready, output, 1 bit: decoder can accept a word.
REQ-009 SHALL have port data_out, output, BW bits: decoded word at the FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port clr_stats, input, 1 bit: synchronous clear of the statistics.
REQ-013 SHALL have port inv_cnt, output, CW bits: number of accepted words decoded as inverted.
REQ-014 SHALL have port viol_cnt, output, CW bits: number of accepted words that broke the transition bound.
REQ-015 SHALL have port viol_sticky, output, 1 bit: at least one violation since the last clear.

Function
REQ-016 SHALL define accept = in_valid & in_ready, and pop = out_valid & out_ready.
REQ-017 SHALL decode on accept: if dbi_en=1 and data_in[BW]=1, the stored word is ~data_in[BW-1:0]; otherwise it is data_in[BW-1:0].
REQ-018 SHALL hold decoded words in a 2-entry FIFO with write pointer, read pointer and a 2-bit occupancy count (0..2).
REQ-019 SHALL drive in_ready = (count != 2) and out_valid = (count != 0), both from registered state only.
REQ-020 SHALL have latency exactly 1 cycle: a word accepted in cycle N is on data_out with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-021 SHALL keep data_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL leave count unchanged on simultaneous accept and pop at count=1; data order is preserved.
REQ-023 SHALL NOT accept at count=2, since in_ready=0; a pop in that cycle only reduces count to 1.
REQ-024 SHALL wrap the pointers modulo 2.
REQ-025 SHALL keep prev_bus, the raw bus lines of the last accepted word, and update it on every accept.
REQ-026 SHALL, on accept with dbi_en=1, compute the popcount of (prev_bus ^ data_in[BW-1:0]); a value > BW/2 is a violation.
REQ-027 SHALL, on each violation, increment viol_cnt and set viol_sticky.
REQ-028 SHALL NOT perform the violation check when dbi_en=0.
REQ-029 SHALL increment inv_cnt on accept with dbi_en=1 and flag=1.
REQ-030 SHALL saturate inv_cnt and viol_cnt at all-ones; they SHALL NOT wrap.
REQ-031 SHALL, when clr_stats=1, zero inv_cnt, viol_cnt and viol_sticky; an event in the same cycle is discarded (clear wins).
REQ-032 SHALL apply a dbi_en change to words accepted from that cycle on; words already stored are unaffected.

Reset
REQ-033 SHALL, in any cycle with reset=0, set count, pointers, prev_bus, inv_cnt, viol_cnt and viol_sticky to 0.
REQ-034 SHALL drive out_valid=0 and in_ready=1 in the cycle after reset; this applies equally to reset asserted mid-transfer.
REQ-035 SHALL discard stored words on reset; FIFO storage content needs no reset.
REQ-036 SHALL NOT accept any word in a cycle with reset=0.

Structure
REQ-037 SHALL place BW, CW, HALF=BW/2 and the FIFO depth constant (2) in shared package dbi_pkg, used by both the encoder and the decoder.
REQ-038 SHALL implement the popcount in sub-module popcount_bw, a parameterised combinational adder tree with output width $clog2(BW+1) bits.

Verification
REQ-039 Decode: dbi_en=1, data_in={1,128'h0} with out_ready=1 -> next cycle data_out=128'hFFFF...FFFF, out_valid=1, inv_cnt=1.
REQ-040 Backpressure: out_ready=0, push 3 words A, B, C -> in_ready=0 after A and B; C is held; release out_ready -> A, B, C delivered in order, none lost or duplicated.
REQ-041 Violation: after reset, dbi_en=1, push {0, 128'h0000...FFFF_FFFF_FFFF_FFFF_FFFF} (80 ones) -> viol_cnt=1, viol_sticky=1; then push {0, 64 ones} relative to the new prev_bus -> no increment.
REQ-042 Pass-through: dbi_en=0, data_in={1,128'hA5A5...} -> data_out=128'hA5A5..., inv_cnt unchanged, no violation.
REQ-043 Saturation/clear: force 2^16+3 inverted words -> inv_cnt=16'hFFFF; clr_stats with a concurrent inverted accept -> inv_cnt=0.
REQ-044 Mid-stream reset: with count=2, drive reset=0 for one cycle -> out_valid=0, in_ready=1, counters 0, and the next accepted word appears after exactly 1 cycle.
